// File: rtl/adder_result_accumulator_pkg.sv
// Shared definitions for the adder result accumulator: state encoding,
// default widths and the batch counter width.
package adder_result_accumulator_pkg;

    localparam int ADD_IN_WIDTH  = 4;
    localparam int ADD_ACC_WIDTH = 12;
    localparam int CNT_WIDTH     = 8;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/adder_result_accumulator_if.sv
// Handshake bundle between the adder, the accumulator and the batch consumer.
// master = the side driving adder results and out_ready; slave = the accumulator.
interface adder_result_accumulator_if
    import adder_result_accumulator_pkg::*;
#(
    parameter int IN_WIDTH  = ADD_IN_WIDTH,
    parameter int ACC_WIDTH = ADD_ACC_WIDTH
);

    logic                 in_valid;
    logic [IN_WIDTH-1:0]  in_sum;
    logic                 in_c;
    logic                 in_ready;
    logic                 clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_total;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;

    modport master (
        output in_valid, in_sum, in_c, clr, out_ready,
        input  in_ready, out_valid, out_total, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, in_c, clr, out_ready,
        output in_ready, out_valid, out_total, out_count, out_ovf
    );

endinterface

// File: rtl/adder_result_accumulator_fsm.sv
// ACCUM/HOLD control for the accumulator: batch counter, batch-close and
// transfer strobes, registered in_ready/out_valid.
module adder_result_accumulator_fsm
    import adder_result_accumulator_pkg::*;
#(
    parameter int COUNT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 clr,
    input  logic                 out_ready,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic                 accept,
    output logic                 close,
    output logic                 transfer,
    output logic [CNT_WIDTH-1:0] batch_count
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(COUNT - 1);

    acc_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        close    = 1'b0;
        accept   = in_valid & in_ready_q;
        transfer = out_valid_q & out_ready;
        unique case (state_q)
            ST_ACCUM: begin
                if (accept) cnt_d = cnt_q + 1'b1;
                if ((accept && cnt_q == LAST) || (clr && (cnt_q != '0 || accept))) begin
                    close   = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (transfer) begin
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_HOLD);
        // Size of the batch being closed, including a term accepted alongside clr.
        batch_count = cnt_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

endmodule

// File: rtl/adder_result_accumulator.sv
// Accumulates COUNT {c,sum} adder results into a batch total and offers it
// over valid/ready. Define ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module adder_result_accumulator
    import adder_result_accumulator_pkg::*;
#(
    parameter int IN_WIDTH  = ADD_IN_WIDTH,
    parameter int ACC_WIDTH = ADD_ACC_WIDTH,
    parameter int COUNT     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    adder_result_accumulator_if.slave  bus
);

    logic                 accept, close, transfer;
    logic                 in_ready, out_valid;
    logic [CNT_WIDTH-1:0] batch_count;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0] out_total_q, out_total_d;
    logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                 out_ovf_q, out_ovf_d;

    logic [ACC_WIDTH:0]   term;
    logic [ACC_WIDTH:0]   sum;

    adder_result_accumulator_fsm #(
        .COUNT (COUNT)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (bus.in_valid),
        .clr         (bus.clr),
        .out_ready   (bus.out_ready),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .accept      (accept),
        .close       (close),
        .transfer    (transfer),
        .batch_count (batch_count)
    );

    // One bit wider than the accumulator so the top bit is the overflow carry.
    assign term = {{(ACC_WIDTH - IN_WIDTH){1'b0}}, bus.in_c, bus.in_sum};
    assign sum  = {1'b0, acc_q} + term;

    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_total_d = out_total_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        if (transfer) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (accept) begin
            ovf_d = ovf_q | sum[ACC_WIDTH];
`ifdef ACC_SATURATE_EN
            acc_d = ovf_d ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
            acc_d = sum[ACC_WIDTH-1:0];
`endif
        end
        // The closing term (if any) is already folded into acc_d/ovf_d.
        if (close) begin
            out_total_d = acc_d;
            out_count_d = batch_count;
            out_ovf_d   = ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_total_q <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_total_q <= out_total_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_total = out_total_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Bench for adder_result_accumulator: table-driven handshake vectors with a
// batch scoreboard (COUNT=4, ACC_WIDTH=6) plus a COUNT=1 streaming instance.
module tb_adder_result_accumulator;

    typedef struct {
        logic       in_valid;
        logic       in_c;
        logic [3:0] in_sum;
        logic       clr;
        logic       out_ready;
        logic       exp_in_ready;
        logic       exp_out_valid;
        logic       push;
        int         exp_total;
        int         exp_count;
        int         exp_ovf;
    } vec_t;

    typedef struct {
        int total;
        int count;
        int ovf;
    } batch_t;

`ifdef ACC_SATURATE_EN
    localparam int OVF_TOTAL = 63;
`else
    localparam int OVF_TOTAL = 29;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_result_accumulator_if #(.IN_WIDTH(4), .ACC_WIDTH(6)) a_if ();
    adder_result_accumulator_if #(.IN_WIDTH(4), .ACC_WIDTH(6)) b_if ();

    adder_result_accumulator #(.IN_WIDTH(4), .ACC_WIDTH(6), .COUNT(4)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    adder_result_accumulator #(.IN_WIDTH(4), .ACC_WIDTH(6), .COUNT(1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    int     checks = 0;
    int     errors = 0;
    vec_t   vecs[$];
    batch_t exp_q[$];
    int     b_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_row(input logic v, input int val, input logic clr, input logic ordy,
                           input logic eir, input logic eov, input logic push,
                           input int tot, input int cnt, input int ovf);
        vec_t r;
        logic [4:0] vb;
        vb = 5'(val);
        r.in_valid = v;     r.in_c = vb[4];        r.in_sum = vb[3:0];
        r.clr = clr;        r.out_ready = ordy;
        r.exp_in_ready = eir; r.exp_out_valid = eov;
        r.push = push;      r.exp_total = tot;     r.exp_count = cnt; r.exp_ovf = ovf;
        vecs.push_back(r);
    endtask

    // Compare the presented batch against the scoreboard head; pop on transfer.
    task automatic score_a();
        batch_t b;
        if (a_if.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_batch: got total %0d, no batch expected", a_if.out_total);
            end else begin
                b = exp_q[0];
                check("out_total", int'(a_if.out_total), b.total);
                check("out_count", int'(a_if.out_count), b.count);
                check("out_ovf", int'(a_if.out_ovf), b.ovf);
                if (a_if.out_ready) void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic apply_row(input vec_t r);
        batch_t b;
        a_if.in_valid  = r.in_valid;
        a_if.in_c      = r.in_c;
        a_if.in_sum    = r.in_sum;
        a_if.clr       = r.clr;
        a_if.out_ready = r.out_ready;
        if (r.push) begin
            b.total = r.exp_total;
            b.count = r.exp_count;
            b.ovf   = r.exp_ovf;
            exp_q.push_back(b);
        end
        @(negedge clk);
        check("in_ready", int'(a_if.in_ready), int'(r.exp_in_ready));
        check("out_valid", int'(a_if.out_valid), int'(r.exp_out_valid));
        score_a();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("rst_in_ready", int'(a_if.in_ready), 1);
        check("rst_out_valid", int'(a_if.out_valid), 0);
        check("rst_out_total", int'(a_if.out_total), 0);
        check("rst_out_count", int'(a_if.out_count), 0);
        check("rst_out_ovf", int'(a_if.out_ovf), 0);
    endtask

    initial begin
        int   n_out;
        logic prev_ov;

        a_if.in_valid = 1'b0; a_if.in_c = 1'b0; a_if.in_sum = '0;
        a_if.clr = 1'b0;      a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_c = 1'b0; b_if.in_sum = '0;
        b_if.clr = 1'b0;      b_if.out_ready = 1'b1;

        //        v  val clr rdy eir eov push tot        cnt ovf
        // Four accepts of 5 -> total 20.
        add_row(1,  5, 0, 0, 1, 0, 0,  0,        0, 0);
        add_row(1,  5, 0, 0, 1, 0, 0,  0,        0, 0);
        add_row(1,  5, 0, 0, 1, 0, 0,  0,        0, 0);
        add_row(1,  5, 0, 0, 1, 0, 1, 20,        4, 0);
        // HOLD with out_ready low: inputs ignored, outputs stable.
        for (int i = 0; i < 5; i++) add_row(1, 31, 0, 0, 0, 1, 0, 0, 0, 0);
        add_row(1, 31, 0, 1, 0, 1, 0,  0,        0, 0);
        add_row(0,  0, 0, 1, 1, 0, 0,  0,        0, 0);
        // 3 + 7, then clr together with an accept of 1.
        add_row(1,  3, 0, 0, 1, 0, 0,  0,        0, 0);
        add_row(1,  7, 0, 0, 1, 0, 0,  0,        0, 0);
        add_row(1,  1, 1, 0, 1, 0, 1, 11,        3, 0);
        add_row(0,  0, 0, 1, 0, 1, 0,  0,        0, 0);
        // clr with nothing accumulated is ignored.
        add_row(0,  0, 1, 1, 1, 0, 0,  0,        0, 0);
        add_row(0,  0, 0, 1, 1, 0, 0,  0,        0, 0);
        // 3 x 31 overflows a 6-bit total.
        add_row(1, 31, 0, 0, 1, 0, 0,  0,        0, 0);
        add_row(1, 31, 0, 0, 1, 0, 0,  0,        0, 0);
        add_row(1, 31, 1, 0, 1, 0, 1, OVF_TOTAL, 3, 1);
        add_row(0,  0, 0, 1, 0, 1, 0,  0,        0, 0);
        add_row(0,  0, 0, 1, 1, 0, 0,  0,        0, 0);
        // Fresh batch after overflow: acc and ovf start clean.
        add_row(1,  0, 0, 0, 1, 0, 0,  0,        0, 0);
        add_row(1, 16, 0, 0, 1, 0, 0,  0,        0, 0);
        add_row(1,  2, 0, 0, 1, 0, 0,  0,        0, 0);
        add_row(1,  9, 0, 0, 1, 0, 1, 27,        4, 0);
        add_row(0,  0, 0, 1, 0, 1, 0,  0,        0, 0);
        add_row(0,  0, 0, 1, 1, 0, 0,  0,        0, 0);

        do_reset();
        foreach (vecs[i]) apply_row(vecs[i]);
        check("scoreboard_drained", exp_q.size(), 0);

        // Reset mid-batch (in_valid still high), then a full batch from cnt=0.
        vecs.delete();
        add_row(1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        foreach (vecs[i]) apply_row(vecs[i]);
        do_reset();
        vecs.delete();
        add_row(1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(1, 2, 0, 0, 1, 0, 1, 8, 4, 0);
        add_row(1, 2, 0, 0, 0, 1, 0, 0, 0, 0);
        foreach (vecs[i]) apply_row(vecs[i]);
        // Reset while holding a pending total: it is discarded.
        do_reset();
        vecs.delete();
        add_row(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        add_row(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        foreach (vecs[i]) apply_row(vecs[i]);

        // COUNT=1 streaming: one result every two cycles, total equals input.
        n_out   = 0;
        prev_ov = 1'b0;
        for (int i = 0; i < 12; i++) begin
            logic [4:0] vb;
            vb = 5'((i * 7 + 3) % 32);
            b_if.in_valid = 1'b1;
            b_if.in_c     = vb[4];
            b_if.in_sum   = vb[3:0];
            @(negedge clk);
            if (i > 0) check("b_alternate", int'(b_if.out_valid), int'(!prev_ov));
            prev_ov = b_if.out_valid;
            if (b_if.in_ready) b_q.push_back(int'(vb));
            if (b_if.out_valid) begin
                n_out++;
                if (b_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got total %0d, no result expected", b_if.out_total);
                end else begin
                    check("b_out_total", int'(b_if.out_total), b_q.pop_front());
                    check("b_out_count", int'(b_if.out_count), 1);
                end
            end
            @(posedge clk);
            #1;
        end
        b_if.in_valid = 1'b0;
        check("b_outputs", n_out, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
